booth_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one Booth multiplier core between NUM_REQ requesters.
It arbitrates requests, latches the winner's operands, and drives the core's level-sensitive enable. It waits for the core's finish flag, returns the product and a done pulse to the winner, then releases the core so it passes through its IDLE (register-clear) state before the next job.
It sits between the client blocks and the existing Booth datapath/FSM.

---
 rtl/booth_mul_arbiter_if.sv | 30 +++
 rtl/booth_mul_arbiter.sv | 146 ++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arbiter_if.sv
// Bus between the requesters, the round-robin scheduler and the shared Booth core.
// The slave modport is the scheduler's view; master is the environment's view.
interface booth_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] mcand_i;
  logic [NUM_REQ*DATA_W-1:0] mplier_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic [2*DATA_W-1:0]       product_o;
  logic                      err_o;
  logic                      busy_o;
  logic                      mul_enable_o;
  logic [DATA_W-1:0]         mul_a_o;
  logic [DATA_W-1:0]         mul_b_o;
  logic                      mul_finish_i;
  logic [2*DATA_W-1:0]       mul_product_i;

  modport slave (
    input  req_i, mcand_i, mplier_i, mul_finish_i, mul_product_i,
    output gnt_o, done_o, product_o, err_o, busy_o, mul_enable_o, mul_a_o, mul_b_o
  );

  modport master (
    output req_i, mcand_i, mplier_i, mul_finish_i, mul_product_i,
    input  gnt_o, done_o, product_o, err_o, busy_o, mul_enable_o, mul_a_o, mul_b_o
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin scheduler sharing one Booth multiplier core between NUM_REQ clients,
// with a BUSY timeout and a forced pass through the core's idle state between jobs.
module booth_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                  clk_i,
  input logic                  reset_i,
  booth_mul_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BUSY, ST_RELEASE} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [2*DATA_W-1:0]  product_q, product_d;
  logic                 err_q, err_d;
  logic                 enable_q, enable_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0]    mcand_arr  [NUM_REQ];
  logic [DATA_W-1:0]    mplier_arr [NUM_REQ];
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W:0]       idx_ext;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign mcand_arr[gi]  = bus.mcand_i[gi*DATA_W +: DATA_W];
      assign mplier_arr[gi] = bus.mplier_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_ext   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_ext = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (idx_ext >= (PTR_W+1)'(NUM_REQ)) begin
        idx_ext = idx_ext - (PTR_W+1)'(NUM_REQ);
      end
      if (!win_found && bus.req_i[idx_ext[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_ext[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    product_d = product_q;
    err_d     = err_q;
    enable_d  = enable_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d   = NUM_REQ'(1) << win_idx;
          a_d     = mcand_arr[win_idx];
          b_d     = mplier_arr[win_idx];
          ptr_d   = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        enable_d = 1'b1;
        cnt_d    = '0;
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A finish seen on the expiry cycle still delivers the real product.
        if (bus.mul_finish_i) begin
          product_d = bus.mul_product_i;
          done_d    = gnt_q;
          gnt_d     = '0;
          enable_d  = 1'b0;
          state_d   = ST_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
          err_d     = 1'b1;
          product_d = '0;
          done_d    = gnt_q;
          gnt_d     = '0;
          enable_d  = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.mul_finish_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
      enable_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      product_q <= product_d;
      err_q     <= err_d;
      enable_q  <= enable_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.done_o       = done_q;
  assign bus.product_o    = product_q;
  assign bus.err_o        = err_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.mul_enable_o = enable_q;
  assign bus.mul_a_o      = a_q;
  assign bus.mul_b_o      = b_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized bench for booth_mul_arbiter: a behavioural Booth core plus a
// transaction-level round-robin/product model checks every job.
module tb_booth_mul_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  booth_mul_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  booth_mul_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(255)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Environment-side configuration of the behavioural core
  int core_lat;
  int core_hold;
  bit core_stall;
  int core_cnt;
  int hold_left;

  // Bench-side reference state
  logic [DW-1:0] mc [NR];
  logic [DW-1:0] mp [NR];
  logic [NR-1:0] req_cur;
  int  ptr_m;
  bit  err_m;
  bit  prev_stall;
  int  prev_hold;

  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (2*DW)'(sa * sb);
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  // Behavioural Booth core: finish after core_lat enabled cycles, held while
  // enabled and for core_hold extra cycles after enable drops.
  always @(posedge clk) begin
    if (rst) begin
      core_cnt         <= 0;
      hold_left        <= 0;
      bus.mul_finish_i <= 1'b0;
    end else if (bus.mul_enable_o) begin
      core_cnt  <= core_cnt + 1;
      hold_left <= core_hold;
      if (!core_stall && core_cnt + 1 >= core_lat) begin
        bus.mul_finish_i  <= 1'b1;
        bus.mul_product_i <= ref_mul(bus.mul_a_o, bus.mul_b_o);
      end
    end else begin
      core_cnt <= 0;
      if (hold_left > 0) hold_left <= hold_left - 1;
      else bus.mul_finish_i <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      bus.mcand_i[k*DW +: DW]  = mc[k];
      bus.mplier_i[k*DW +: DW] = mp[k];
    end
    bus.req_i = req_cur;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NR; k++) begin
      mc[k] = DW'($urandom);
      mp[k] = DW'($urandom);
    end
  endtask

  // One complete job: grant, operand latch, enable, done/product, release.
  task automatic do_job(input bit stall, input bit from_idle);
    int w;
    int glat;
    int exp_lat;
    int en_cnt;
    int n;
    bit gnt_ok;
    logic [2*DW-1:0] expp;
    core_stall = stall;
    w = pick(req_cur, ptr_m);
    exp_lat = (from_idle || prev_stall) ? 1 : 2 + prev_hold;
    glat = 0;
    do begin
      @(negedge clk);
      glat++;
    end while (bus.gnt_o == '0 && glat < 50);
    if (bus.gnt_o == '0) begin
      check("gnt_wait", 32'(glat), 32'(exp_lat));
      return;
    end
    check("gnt_lat", 32'(glat), 32'(exp_lat));
    check("gnt", 32'(bus.gnt_o), 32'(1) << w);
    check("mul_a", 32'(bus.mul_a_o), 32'(mc[w]));
    check("mul_b", 32'(bus.mul_b_o), 32'(mp[w]));
    check("en_pre", 32'(bus.mul_enable_o), 32'(0));
    @(negedge clk);
    check("en_rise", 32'(bus.mul_enable_o), 32'(1));
    en_cnt = 1;
    n = 0;
    gnt_ok = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (bus.done_o != '0 || n > 400) break;
      if (bus.gnt_o != NR'(1 << w)) gnt_ok = 1'b0;
      if (bus.mul_enable_o) en_cnt++;
    end
    check("gnt_hold", 32'(gnt_ok), 32'(1));
    if (bus.done_o == '0) begin
      check("done_wait", 32'(n), 32'(0));
      return;
    end
    expp = stall ? '0 : ref_mul(mc[w], mp[w]);
    if (stall) err_m = 1'b1;
    $display("job req=%b win=%0d a=%0d b=%0d prod=%0h stall=%0d", req_cur, w,
             $signed(mc[w]), $signed(mp[w]), bus.product_o, stall);
    check("done", 32'(bus.done_o), 32'(1) << w);
    check("product", 32'(bus.product_o), 32'(expp));
    check("gnt_rel", 32'(bus.gnt_o), 32'(0));
    check("en_rel", 32'(bus.mul_enable_o), 32'(0));
    check("busy_cyc", 32'(en_cnt), stall ? 32'(255) : 32'(core_lat + 1));
    check("err", 32'(bus.err_o), 32'(err_m));
    @(negedge clk);
    check("done_pulse", 32'(bus.done_o), 32'(0));
    check("prod_hold", 32'(bus.product_o), 32'(expp));
    ptr_m = (w + 1) % NR;
    prev_stall = stall;
    prev_hold = core_hold;
  endtask

  task automatic go_idle();
    req_cur = '0;
    drive_inputs();
    repeat (8) @(negedge clk);
    check("idle_busy", 32'(bus.busy_o), 32'(0));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    core_lat = 3;
    core_hold = 0;
    core_stall = 1'b0;
    bus.mul_product_i = '0;
    ptr_m = 0;
    err_m = 1'b0;
    prev_stall = 1'b0;
    prev_hold = 0;
    req_cur = '0;
    rand_ops();
    drive_inputs();
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt_o), 32'(0));
    check("rst_done", 32'(bus.done_o), 32'(0));
    check("rst_prod", 32'(bus.product_o), 32'(0));
    check("rst_err", 32'(bus.err_o), 32'(0));
    check("rst_busy", 32'(bus.busy_o), 32'(0));
    check("rst_en", 32'(bus.mul_enable_o), 32'(0));
    rst = 1'b0;

    // Single job: 7 * -3 = -21
    mc[0] = 8'd7;
    mp[0] = 8'hFD;
    req_cur = 4'b0001;
    drive_inputs();
    do_job(1'b0, 1'b1);
    check("single_prod", 32'(bus.product_o), 32'h0000FFEB);
    go_idle();

    // Round robin with all requesters asserted
    rand_ops();
    req_cur = 4'b1111;
    drive_inputs();
    do_job(1'b0, 1'b1);
    for (int j = 0; j < 4; j++) do_job(1'b0, 1'b0);

    // Pointer wrap: grant 3, then 1001 gives 0 then 3
    req_cur = 4'b1000;
    drive_inputs();
    do_job(1'b0, 1'b0);
    req_cur = 4'b1001;
    drive_inputs();
    do_job(1'b0, 1'b0);
    do_job(1'b0, 1'b0);

    // Release spacing: finish held 3 cycles after enable drops
    core_hold = 3;
    req_cur = 4'b0001;
    drive_inputs();
    do_job(1'b0, 1'b0);
    do_job(1'b0, 1'b0);
    core_hold = 0;

    // Timeout, then a normal job with err still set
    req_cur = 4'b0100;
    drive_inputs();
    do_job(1'b1, 1'b0);
    rand_ops();
    req_cur = 4'b0010;
    drive_inputs();
    do_job(1'b0, 1'b0);
    go_idle();
    check("err_sticky", 32'(bus.err_o), 32'(1));

    // Randomized chained jobs
    for (int j = 0; j < 30; j++) begin
      rand_ops();
      req_cur = NR'($urandom_range(1, (1 << NR) - 1));
      core_lat = $urandom_range(1, 6);
      core_hold = $urandom_range(0, 2);
      drive_inputs();
      do_job(1'b0, j == 0);
    end
    go_idle();

    // Reset in the middle of a stalled job
    rand_ops();
    req_cur = 4'b0100;
    drive_inputs();
    core_stall = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    req_cur = '0;
    drive_inputs();
    @(negedge clk);
    check("mid_gnt", 32'(bus.gnt_o), 32'(0));
    check("mid_done", 32'(bus.done_o), 32'(0));
    check("mid_prod", 32'(bus.product_o), 32'(0));
    check("mid_err", 32'(bus.err_o), 32'(0));
    check("mid_busy", 32'(bus.busy_o), 32'(0));
    check("mid_en", 32'(bus.mul_enable_o), 32'(0));
    check("mid_a", 32'(bus.mul_a_o), 32'(0));
    check("mid_b", 32'(bus.mul_b_o), 32'(0));
    rst = 1'b0;
    core_stall = 1'b0;
    ptr_m = 0;
    err_m = 1'b0;
    req_cur = 4'b0010;
    drive_inputs();
    do_job(1'b0, 1'b1);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
